// File: rtl/cbus_mem_responder_pkg.sv
// Shared CBus types and burst helpers for the memory responder.
package cbus_mem_responder_pkg;

   // Encoded burst length: beats = len + 1, and len doubles as the wrap mask.
   typedef enum logic [3:0] {
      MLEN1  = 4'd0,
      MLEN2  = 4'd1,
      MLEN4  = 4'd3,
      MLEN8  = 4'd7,
      MLEN16 = 4'd15
   } cbus_len_t;

   typedef enum logic [1:0] {
      SIZE_B = 2'd0,
      SIZE_H = 2'd1,
      SIZE_W = 2'd2
   } cbus_size_t;

   typedef struct packed {
      logic       valid;
      logic       is_write;
      cbus_size_t size;
      logic [31:0] addr;
      logic [3:0]  strobe;
      logic [31:0] data;
      cbus_len_t   len;
   } cbus_req_t;

   typedef struct packed {
      logic        ready;
      logic        last;
      logic [31:0] data;
   } cbus_resp_t;

   function automatic logic [4:0] len_to_beats(input cbus_len_t len);
      return {1'b0, len} + 5'd1;
   endfunction

   // Low index bits of beat cnt: bits covered by the len mask wrap, the rest stay fixed.
   function automatic logic [3:0] wrap_index(input logic [3:0] start,
                                             input logic [3:0] cnt,
                                             input cbus_len_t  len);
      logic [3:0] mask;
      mask = len;
      return (start & ~mask) | ((start + cnt) & mask);
   endfunction

endpackage

// File: rtl/cbus_mem_responder_if.sv
// CBus request/response bundle between an initiator and the memory responder.
interface cbus_mem_responder_if;
   import cbus_mem_responder_pkg::*;

   cbus_req_t  creq;
   cbus_resp_t cresp;

   modport master (output creq, input cresp);
   modport slave  (input creq, output cresp);
endinterface

// File: rtl/cbus_mem_responder_ram.sv
// Single-port word RAM with byte-lane write enables and a fixed read pipeline; no reset.
module RAM_SinglePort #(
   parameter int unsigned ADDR_WIDTH   = 14,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned BYTE_WIDTH   = 8,
   parameter int unsigned READ_LATENCY = 1
) (
   input  logic                             clk_i,
   input  logic                             en_i,
   input  logic [DATA_WIDTH/BYTE_WIDTH-1:0] we_i,
   input  logic [ADDR_WIDTH-1:0]            addr_i,
   input  logic [DATA_WIDTH-1:0]            wdata_i,
   output logic [DATA_WIDTH-1:0]            rdata_o
);
   localparam int unsigned NB = DATA_WIDTH / BYTE_WIDTH;

   logic [DATA_WIDTH-1:0] mem_q     [2**ADDR_WIDTH];
   logic [DATA_WIDTH-1:0] rd_pipe_q [READ_LATENCY];

   // Array access on enable (read old data, write enabled lanes), then the read pipeline.
   always_ff @(posedge clk_i) begin
      if (en_i) begin
         rd_pipe_q[0] <= mem_q[addr_i];
         for (int unsigned b = 0; b < NB; b++) begin
            if (we_i[b]) begin
               mem_q[addr_i][b*BYTE_WIDTH +: BYTE_WIDTH] <= wdata_i[b*BYTE_WIDTH +: BYTE_WIDTH];
            end
         end
      end
      for (int unsigned s = 1; s < READ_LATENCY; s++) begin
         rd_pipe_q[s] <= rd_pipe_q[s-1];
      end
   end

   assign rdata_o = rd_pipe_q[READ_LATENCY-1];
endmodule

// File: rtl/cbus_mem_responder.sv
// CBus memory responder: fixed-latency single/burst reads and writes with block wrap.
module cbus_mem_responder
   import cbus_mem_responder_pkg::*;
#(
   parameter int unsigned MEM_ADDR_BITS = 14,
   parameter int unsigned LATENCY       = 2    // legal range 1..15
) (
   input  logic                  clk,
   input  logic                  resetn,
   cbus_mem_responder_if.slave   cbus
);
   typedef enum logic [1:0] {IDLE, WAIT, BURST} state_t;

   state_t                   state_q;
   logic [3:0]               wait_cnt_q;
   logic [3:0]               beat_cnt_q;
   logic                     is_write_q;
   cbus_len_t                len_q;
   logic [MEM_ADDR_BITS-1:0] start_q;
   logic                     ready_q;
   logic                     last_q;
   logic                     rd_en_q;

   logic [3:0]               last_beat;
   logic [3:0]               ram_cnt;
   logic                     ram_en;
   logic [3:0]               ram_we;
   logic [MEM_ADDR_BITS-1:0] ram_addr;
   logic [31:0]              ram_rdata;
   logic                     unused;

   assign last_beat = 4'(len_to_beats(len_q) - 5'd1);
   assign ram_addr  = {start_q[MEM_ADDR_BITS-1:4], wrap_index(start_q[3:0], ram_cnt, len_q)};

   // RAM access: reads run one beat ahead of the response, writes land on the current beat.
   always_comb begin
      ram_en  = 1'b0;
      ram_we  = '0;
      ram_cnt = beat_cnt_q;
      unique case (state_q)
         WAIT: begin
            if (wait_cnt_q == 4'd0 && !is_write_q) begin
               ram_en  = 1'b1;
               ram_cnt = 4'd0;
            end
         end
         BURST: begin
            if (is_write_q) begin
               ram_en = 1'b1;
               ram_we = cbus.creq.strobe;
            end else if (beat_cnt_q != last_beat) begin
               ram_en  = 1'b1;
               ram_cnt = beat_cnt_q + 4'd1;
            end
         end
         default: ;
      endcase
   end

   // Responder FSM with registered ready/last and read-data gate.
   always_ff @(posedge clk or negedge resetn) begin
      if (!resetn) begin
         state_q    <= IDLE;
         wait_cnt_q <= '0;
         beat_cnt_q <= '0;
         is_write_q <= 1'b0;
         len_q      <= MLEN1;
         start_q    <= '0;
         ready_q    <= 1'b0;
         last_q     <= 1'b0;
         rd_en_q    <= 1'b0;
      end else begin
         unique case (state_q)
            IDLE: begin
               ready_q <= 1'b0;
               last_q  <= 1'b0;
               rd_en_q <= 1'b0;
               if (cbus.creq.valid) begin
                  is_write_q <= cbus.creq.is_write;
                  len_q      <= cbus.creq.len;
                  start_q    <= cbus.creq.addr[MEM_ADDR_BITS+1:2];
                  wait_cnt_q <= 4'(LATENCY - 1);
                  beat_cnt_q <= '0;
                  state_q    <= WAIT;
               end
            end
            WAIT: begin
               if (wait_cnt_q == 4'd0) begin
                  state_q <= BURST;
                  ready_q <= 1'b1;
                  last_q  <= (last_beat == 4'd0);
                  rd_en_q <= !is_write_q;
               end else begin
                  wait_cnt_q <= wait_cnt_q - 4'd1;
               end
            end
            BURST: begin
               if (beat_cnt_q == last_beat) begin
                  state_q <= IDLE;
                  ready_q <= 1'b0;
                  last_q  <= 1'b0;
                  rd_en_q <= 1'b0;
               end else begin
                  beat_cnt_q <= beat_cnt_q + 4'd1;
                  last_q     <= (beat_cnt_q + 4'd1 == last_beat);
               end
            end
            default: state_q <= IDLE;
         endcase
      end
   end

   RAM_SinglePort #(
      .ADDR_WIDTH  (MEM_ADDR_BITS),
      .DATA_WIDTH  (32),
      .BYTE_WIDTH  (8),
      .READ_LATENCY(1)
   ) u_ram (
      .clk_i  (clk),
      .en_i   (ram_en),
      .we_i   (ram_we),
      .addr_i (ram_addr),
      .wdata_i(cbus.creq.data),
      .rdata_o(ram_rdata)
   );

   assign cbus.cresp.ready = ready_q;
   assign cbus.cresp.last  = last_q;
   assign cbus.cresp.data  = rd_en_q ? ram_rdata : '0;

   // size never masks data and upper address bits alias.
   assign unused = ^{cbus.creq.size, cbus.creq.addr[31:MEM_ADDR_BITS+2], cbus.creq.addr[1:0]};

   valid_held_a: assert property (@(posedge clk) disable iff (!resetn)
                                  (state_q != IDLE) |-> cbus.creq.valid)
      else $error("creq.valid dropped during an active burst");
endmodule
